// File: rtl/apb_pkg.sv
// Shared APB definitions used by both the slave memory and the APB master.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: loads a start value, counts down to zero and holds there.
module apb_wait_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave backed by a DEPTH x 32-bit register file with WAIT_CYCLES wait states.
// Optional macro APB_SLAVE_MEM_PSLVERR_EN enables address-range checking and pslverr_o.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] BASE_HI     = 16'hDEAD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic                  pwrite_i,
  input  logic [APB_DATA_W-1:0] pwdata_i,
  output logic                  pready_o,
  output logic [APB_DATA_W-1:0] prdata_o,
  output logic                  pslverr_o
);

  localparam int unsigned IW = $clog2(DEPTH);

  apb_state_e state, state_nxt;

  logic                  ctr_load;
  logic                  ctr_dec;
  logic                  ctr_zero;
  logic                  xfer_live;
  logic                  in_range;
  logic                  mem_we;
  logic [IW-1:0]         index;
  logic [APB_DATA_W-1:0] mem [DEPTH];

  assign xfer_live = psel_i & penable_i;
  assign index     = paddr_i[IW+1:2];

  apb_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (4'(WAIT_CYCLES)),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  logic unused_addr_bits;
`ifdef APB_SLAVE_MEM_PSLVERR_EN
  assign in_range         = (paddr_i[31:16] == BASE_HI) &&
                            ((paddr_i[15:0] >> (IW + 2)) == '0);
  assign unused_addr_bits = ^paddr_i[1:0];
`else
  assign in_range         = 1'b1;
  assign unused_addr_bits = ^{paddr_i[31:IW+2], paddr_i[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (psel_i && !penable_i) state_nxt = ACCESS;
      ACCESS: if (!xfer_live || ctr_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pready is qualified by a live access phase so a master abort landing on
  // the zero-count cycle neither completes the transfer nor writes memory.
  always_comb begin
    pready_o = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    unique case (state)
      IDLE:   ctr_load = psel_i & ~penable_i;
      ACCESS: begin
        pready_o = xfer_live & ctr_zero;
        ctr_dec  = ~ctr_zero;
      end
      default: ;
    endcase
  end

  assign mem_we = pready_o & pwrite_i & in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[index] <= pwdata_i;
    end
  end

  assign prdata_o = (pready_o && !pwrite_i && in_range) ? mem[index] : '0;

`ifdef APB_SLAVE_MEM_PSLVERR_EN
  assign pslverr_o = pready_o & ~in_range;
`else
  assign pslverr_o = 1'b0;
`endif

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit storage words, power of two, 2..256.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted per access, 0..15.
REQ-003 Parameter BASE_HI, default 16'hDEAD, required value of paddr_i[31:16] for an in-range access.
REQ-004 Port clk  input  1  clock; all state updates on rising edge.
REQ-005 Port reset  input  1  reset, synchronous, active-high.
REQ-006 Port psel_i  input  1  APB select from master.
REQ-007 Port penable_i  input  1  APB enable, access phase.
REQ-008 Port paddr_i  input  32  byte address; word index = paddr_i[log2(DEPTH)+1:2]; bits [1:0] ignored.
REQ-009 Port pwrite_i  input  1  1 = write, 0 = read.
REQ-010 Port pwdata_i  input  32  write data.
REQ-011 Port pready_o  output  1  transfer completes in the cycle it is high.
REQ-012 Port prdata_o  output  32  read data, valid only when pready_o is high on a read.
REQ-013 Port pslverr_o  output  1  error response, valid only when pready_o is high.

Function
REQ-014 FSM states IDLE, ACCESS; reset state IDLE.
REQ-015 IDLE: psel_i=1 and penable_i=0 (setup phase) -> load wait counter with WAIT_CYCLES, go ACCESS; otherwise stay IDLE.
REQ-016 ACCESS: counter decrements by 1 each cycle while non-zero; pready_o = 1 exactly when state is ACCESS and counter is 0, combinationally.
REQ-017 First access-phase cycle is setup+1; pready_o is high in cycle setup+1+WAIT_CYCLES, for exactly one cycle per transfer.
REQ-018 On the pready_o cycle with pwrite_i=1 and in-range, mem[index] <= pwdata_i at that clock edge; no other cycle writes memory.
REQ-019 On the pready_o cycle with pwrite_i=0, prdata_o = mem[index]; in all other cycles prdata_o = 0.
REQ-020 After the pready_o cycle, FSM returns to IDLE; a setup phase in the following cycle is accepted normally (back-to-back, no dead cycle).
REQ-021 Read of a word written by the immediately preceding transfer returns the new value.
REQ-022 In ACCESS, psel_i=0 or penable_i=0 (master abort) -> IDLE next cycle, no memory write, pready_o stays 0.
REQ-023 paddr_i, pwrite_i, pwdata_i are sampled on the pready_o cycle; their values in earlier access cycles do not matter.
REQ-024 penable_i=1 while in IDLE is ignored; no transfer starts.

Reset
REQ-025 Reset -> FSM IDLE, counter 0, all DEPTH memory words 0; pready_o=0, prdata_o=0, pslverr_o=0 in the cycle after reset asserts.
REQ-026 Reset during ACCESS abandons the transfer; no write occurs on that edge.

Configuration
REQ-027 Macro APB_SLAVE_MEM_PSLVERR_EN defined: access with paddr_i[31:16] != BASE_HI, or paddr_i[15:log2(DEPTH)+2] != 0, is out-of-range; its pready_o cycle drives pslverr_o=1 and prdata_o=0, and writes are suppressed.
REQ-028 Macro not defined: pslverr_o tied 0, upper address bits ignored, every access aliases onto mem[index] and writes always commit.

Structure
REQ-029 Package apb_pkg holds state enum (IDLE, ACCESS), APB_ADDR_W=32, APB_DATA_W=32; shared with the APB master.
REQ-030 Sub-module apb_wait_ctr (4-bit load/decrement counter with zero flag) implements the wait counter; storage and FSM stay in apb_slave_mem.

Verification
REQ-031 Defaults; write 0x0000_0005 to 0xDEAD_0008 -> pready_o high in setup+3, mem[2]=5; then read 0xDEAD_0008 -> prdata_o=0x0000_0005, pslverr_o=0.
REQ-032 WAIT_CYCLES=0; back-to-back write 0x1 then read, same address -> pready_o in setup+1 each time, read returns 0x1, no idle cycle between transfers.
REQ-033 Read 0xDEAD_CAFC after reset -> prdata_o=0; write 0xFFFF_FFFF there, then read 0xDEAD_003C -> 0xFFFF_FFFF (index 15; aliasing only without the macro).
REQ-034 With APB_SLAVE_MEM_PSLVERR_EN, write 0x1234_5678 to 0xBEEF_0000 -> pslverr_o=1 on pready_o cycle, mem[0] unchanged at 0.
REQ-035 Drop psel_i in second access cycle of a write (WAIT_CYCLES=2) -> no pready_o, memory unchanged, next setup accepted.
REQ-036 Assert reset in ACCESS one cycle before pready_o would rise -> no write, outputs 0, all words read back 0.
